// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - two-requester round-robin AXI4-Lite master sequencer
// One AXI4-Lite transaction outstanding at a time; response pulsed back to the granted requester.
module axi_lite_master_arbiter #(
  parameter int C_M_AXI_LITE_ADDR_WIDTH = 32,
  parameter int C_M_AXI_LITE_DATA_WIDTH = 32
) (
  input  logic                                   M_AXI_LITE_ACLK,
  input  logic                                   M_AXI_LITE_ARESETN,
  input  logic [1:0]                             REQ_VALID,
  output logic [1:0]                             REQ_READY,
  input  logic [1:0]                             REQ_WRITE,
  input  logic [2*C_M_AXI_LITE_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [2*C_M_AXI_LITE_DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [2*C_M_AXI_LITE_DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic [1:0]                             RSP_VALID,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                             RSP_RESP,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_LITE_AWADDR,
  output logic [2:0]                             M_AXI_LITE_AWPROT,
  output logic                                   M_AXI_LITE_AWVALID,
  input  logic                                   M_AXI_LITE_AWREADY,
  output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_LITE_WDATA,
  output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]   M_AXI_LITE_WSTRB,
  output logic                                   M_AXI_LITE_WVALID,
  input  logic                                   M_AXI_LITE_WREADY,
  input  logic [1:0]                             M_AXI_LITE_BRESP,
  input  logic                                   M_AXI_LITE_BVALID,
  output logic                                   M_AXI_LITE_BREADY,
  output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]     M_AXI_LITE_ARADDR,
  output logic [2:0]                             M_AXI_LITE_ARPROT,
  output logic                                   M_AXI_LITE_ARVALID,
  input  logic                                   M_AXI_LITE_ARREADY,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]     M_AXI_LITE_RDATA,
  input  logic [1:0]                             M_AXI_LITE_RRESP,
  input  logic                                   M_AXI_LITE_RVALID,
  output logic                                   M_AXI_LITE_RREADY
);
  localparam int AW = C_M_AXI_LITE_ADDR_WIDTH;
  localparam int DW = C_M_AXI_LITE_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WADDR = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;

  logic gnt_any, gnt_idx, aw_fire, w_fire;

  // Accept is decided in the IDLE cycle itself so back-to-back grants stay 4 cycles apart.
  assign gnt_any   = M_AXI_LITE_ARESETN && (state_q == ST_IDLE) && (|REQ_VALID);
  assign gnt_idx   = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
  assign REQ_READY = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign aw_fire   = awvalid_q && M_AXI_LITE_AWREADY;
  assign w_fire    = wvalid_q && M_AXI_LITE_WREADY;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          last_d  = gnt_idx;
          owner_d = gnt_idx;
          addr_d  = gnt_idx ? REQ_ADDR[AW +: AW] : REQ_ADDR[0 +: AW];
          wdata_d = gnt_idx ? REQ_WDATA[DW +: DW] : REQ_WDATA[0 +: DW];
          wstrb_d = gnt_idx ? REQ_WSTRB[SW +: SW] : REQ_WSTRB[0 +: SW];
          if (REQ_WRITE[gnt_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        // A channel is finished if it already dropped or handshakes on this edge.
        if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (M_AXI_LITE_BVALID) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_LITE_BRESP;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = ST_DONE;
        end
      end
      ST_RADDR: begin
        if (M_AXI_LITE_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (M_AXI_LITE_RVALID) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_LITE_RDATA;
          rsp_resp_d  = M_AXI_LITE_RRESP;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_LITE_ACLK) begin
    if (!M_AXI_LITE_ARESETN) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign M_AXI_LITE_AWADDR  = addr_q;
  assign M_AXI_LITE_ARADDR  = addr_q;
  assign M_AXI_LITE_AWPROT  = 3'b000;
  assign M_AXI_LITE_ARPROT  = 3'b000;
  assign M_AXI_LITE_AWVALID = awvalid_q;
  assign M_AXI_LITE_WDATA   = wdata_q;
  assign M_AXI_LITE_WSTRB   = wstrb_q;
  assign M_AXI_LITE_WVALID  = wvalid_q;
  assign M_AXI_LITE_BREADY  = bready_q;
  assign M_AXI_LITE_ARVALID = arvalid_q;
  assign M_AXI_LITE_RREADY  = rready_q;
  assign RSP_VALID          = rsp_valid_q;
  assign RSP_RDATA          = rsp_rdata_q;
  assign RSP_RESP           = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - scoreboard bench for axi_lite_master_arbiter
// Bench-side AXI4-Lite slave with per-channel wait knobs and a reference memory.
module tb_axi_lite_master_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  REQ_VALID, REQ_READY, REQ_WRITE, RSP_VALID, RSP_RESP;
  logic [63:0] REQ_ADDR, REQ_WDATA;
  logic [7:0]  REQ_WSTRB;
  logic [31:0] RSP_RDATA, AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  logic        r_valid [2];
  logic        r_write [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wstrb [2];
  assign REQ_VALID = {r_valid[1], r_valid[0]};
  assign REQ_WRITE = {r_write[1], r_write[0]};
  assign REQ_ADDR  = {r_addr[1], r_addr[0]};
  assign REQ_WDATA = {r_wdata[1], r_wdata[0]};
  assign REQ_WSTRB = {r_wstrb[1], r_wstrb[0]};

  axi_lite_master_arbiter dut (
    .M_AXI_LITE_ACLK(clk), .M_AXI_LITE_ARESETN(rstn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AXI_LITE_AWADDR(AWADDR), .M_AXI_LITE_AWPROT(AWPROT),
    .M_AXI_LITE_AWVALID(AWVALID), .M_AXI_LITE_AWREADY(AWREADY),
    .M_AXI_LITE_WDATA(WDATA), .M_AXI_LITE_WSTRB(WSTRB),
    .M_AXI_LITE_WVALID(WVALID), .M_AXI_LITE_WREADY(WREADY),
    .M_AXI_LITE_BRESP(BRESP), .M_AXI_LITE_BVALID(BVALID), .M_AXI_LITE_BREADY(BREADY),
    .M_AXI_LITE_ARADDR(ARADDR), .M_AXI_LITE_ARPROT(ARPROT),
    .M_AXI_LITE_ARVALID(ARVALID), .M_AXI_LITE_ARREADY(ARREADY),
    .M_AXI_LITE_RDATA(RDATA), .M_AXI_LITE_RRESP(RRESP),
    .M_AXI_LITE_RVALID(RVALID), .M_AXI_LITE_RREADY(RREADY)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;

  rsp_t        sb[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  logic [1:0]  last_req_ready;
  int          aw_rise_cyc, aw_hs_cyc, w_hs_cyc, wv_fall_cyc, bready_rise_cyc, ar_hs_cyc, rsp_cyc;
  logic [31:0] aw_rise_addr, w_rise_data;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = st[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction

  // Slave model and output monitor: sample DUT outputs at negedge, then drive slave inputs.
  initial begin
    int          aw_cnt, w_cnt, ar_cnt, b_cnt;
    logic        aw_prev, w_prev, b_prev, p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_araddr, sl_addr, sl_raddr, sl_wdata;
    logic [35:0] p_wbeat;
    logic [3:0]  sl_wstrb;
    rsp_t        e;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
    aw_prev = 0; w_prev = 0; b_prev = 0; p_aw = 0; p_w = 0; p_ar = 0;
    p_awaddr = 0; p_araddr = 0; p_wbeat = 0;
    sl_addr = 0; sl_raddr = 0; sl_wdata = 0; sl_wstrb = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = 0; RRESP = 0; RDATA = 0;
    forever begin
      @(negedge clk);
      if (RSP_VALID != 2'b00) begin
        rsp_cyc = cyc;
        if (sb.size() == 0) chk("rsp_unexpected", {62'd0, RSP_VALID}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_valid", {62'd0, RSP_VALID}, {62'd0, e.v});
          chk("rsp_rdata", {32'd0, RSP_RDATA}, {32'd0, e.d});
          chk("rsp_resp", {62'd0, RSP_RESP}, {62'd0, e.r});
        end
      end
      if (!rstn) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
        aw_prev = 0; w_prev = 0; b_prev = 0; p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw) begin
          chk("aw_hold", {63'd0, AWVALID}, 64'd1);
          chk("aw_addr_stable", {32'd0, AWADDR}, {32'd0, p_awaddr});
        end
        if (p_w) begin
          chk("w_hold", {63'd0, WVALID}, 64'd1);
          chk("w_beat_stable", {28'd0, WSTRB, WDATA}, {28'd0, p_wbeat});
        end
        if (p_ar) begin
          chk("ar_hold", {63'd0, ARVALID}, 64'd1);
          chk("ar_addr_stable", {32'd0, ARADDR}, {32'd0, p_araddr});
        end
        if (AWVALID && !aw_prev) begin aw_rise_cyc = cyc; aw_rise_addr = AWADDR; end
        if (WVALID && !w_prev) w_rise_data = WDATA;
        if (!WVALID && w_prev) wv_fall_cyc = cyc;
        if (BREADY && !b_prev) bready_rise_cyc = cyc;
        aw_prev = AWVALID; w_prev = WVALID; b_prev = BREADY;

        AWREADY = AWVALID && (aw_cnt >= aw_wait);
        if (!AWVALID) aw_cnt = 0; else if (!AWREADY) aw_cnt++;
        if (AWVALID && AWREADY) begin aw_hs_cyc = cyc; sl_addr = AWADDR; end
        WREADY = WVALID && (w_cnt >= w_wait);
        if (!WVALID) w_cnt = 0; else if (!WREADY) w_cnt++;
        if (WVALID && WREADY) begin w_hs_cyc = cyc; sl_wdata = WDATA; sl_wstrb = WSTRB; end
        ARREADY = ARVALID && (ar_cnt >= ar_wait);
        if (!ARVALID) ar_cnt = 0; else if (!ARREADY) ar_cnt++;
        if (ARVALID && ARREADY) begin ar_hs_cyc = cyc; sl_raddr = ARADDR; end

        BVALID = BREADY && (b_cnt >= b_wait);
        if (!BREADY) b_cnt = 0; else if (!BVALID) b_cnt++;
        BRESP = BVALID ? slv_resp : 2'b11;
        if (BVALID) slv_mem[sl_addr[5:2]] = merge(slv_mem[sl_addr[5:2]], sl_wdata, sl_wstrb);
        RVALID = RREADY;
        RDATA  = RVALID ? slv_mem[sl_raddr[5:2]] : 32'hBAD0_BAD0;
        RRESP  = RVALID ? slv_resp : 2'b11;

        p_aw = AWVALID && !AWREADY; p_awaddr = AWADDR;
        p_w  = WVALID && !WREADY;   p_wbeat  = {WSTRB, WDATA};
        p_ar = ARVALID && !ARREADY; p_araddr = ARADDR;
      end
    end
  end

  task automatic req_cmd(input int n, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, output int gc);
    rsp_t e;
    bit   got;
    got = 0;
    gc  = -1;
    @(negedge clk);
    r_valid[n] = 1'b1; r_write[n] = wr; r_addr[n] = addr; r_wdata[n] = wd; r_wstrb[n] = st;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (REQ_READY[n]) begin
        got = 1;
        gc  = cyc;
        last_req_ready = REQ_READY;
        e.v = (n == 1) ? 2'b10 : 2'b01;
        e.r = slv_resp;
        if (wr) begin
          e.d = 32'd0;
          ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, st);
        end else e.d = ref_mem[addr[5:2]];
        sb.push_back(e);
        gnt_log.push_back(n);
        gnt_cyc.push_back(cyc);
        @(posedge clk);
        #1;
      end else @(negedge clk);
    end
    r_valid[n] = 1'b0;
    if (!got) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      @(negedge clk);
      #2;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int t, ta, tb;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 0; r_write[i] = 0; r_addr[i] = 0; r_wdata[i] = 0; r_wstrb[i] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {62'd0, REQ_READY}, 64'd0);
    chk("rst_valids", {58'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, 1'b0}, 64'd0);
    chk("rst_rsp_valid", {62'd0, RSP_VALID}, 64'd0);
    chk("rst_rsp_data", {30'd0, RSP_RESP, RSP_RDATA}, 64'd0);
    chk("rst_addr", {AWADDR, ARADDR}, 64'd0);
    chk("rst_wbeat", {28'd0, WSTRB, WDATA}, 64'd0);
    chk("rst_prot", {58'd0, AWPROT, ARPROT}, 64'd0);
    #1 rstn = 1'b1;

    slv_resp = 2'b00;
    req_cmd(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, t);
    chk("t1_req_ready", {62'd0, last_req_ready}, 64'd1);
    drain();
    chk("t1_aw_cyc", 64'(aw_rise_cyc), 64'(t + 1));
    chk("t1_awaddr", {32'd0, aw_rise_addr}, 64'h10);
    chk("t1_wdata", {32'd0, w_rise_data}, 64'hDEAD_BEEF);
    chk("t1_rsp_cyc", 64'(rsp_cyc), 64'(t + 3));

    slv_mem[9] = 32'h1234_5678;
    ref_mem[9] = 32'h1234_5678;
    slv_resp = 2'b10;
    req_cmd(1, 1'b0, 32'h24, 32'd0, 4'h0, t);
    drain();
    chk("t2_rsp_cyc", 64'(rsp_cyc), 64'(t + 3));

    slv_resp = 2'b00;
    gnt_log.delete();
    gnt_cyc.delete();
    fork
      for (int i = 0; i < 4; i++)
        req_cmd(0, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom, 4'($urandom), ta);
      for (int i = 0; i < 4; i++)
        req_cmd(1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom, 4'($urandom), tb);
    join
    drain();
    chk("rr_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size(); i++) chk("rr_order", 64'(gnt_log[i]), 64'(i % 2));
    for (int i = 1; i < gnt_cyc.size(); i++) chk("rr_spacing", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd4);

    aw_wait = 3;
    req_cmd(0, 1'b1, 32'h18, 32'hA5A5_5A5A, 4'b0101, t);
    drain();
    chk("t5_aw_after_w", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
    chk("t5_wvalid_fall", 64'(wv_fall_cyc), 64'(w_hs_cyc + 1));
    chk("t5_bready_rise", 64'(bready_rise_cyc), 64'(aw_hs_cyc + 1));
    chk("t5_rsp_cyc", 64'(rsp_cyc), 64'(t + 6));
    aw_wait = 0;
    req_cmd(1, 1'b0, 32'h18, 32'd0, 4'h0, t);
    drain();

    ar_wait = 5;
    slv_resp = 2'b01;
    req_cmd(1, 1'b0, 32'h24, 32'd0, 4'h0, t);
    drain();
    chk("t6_ar_hs", 64'(ar_hs_cyc), 64'(t + 6));
    chk("t6_rsp_cyc", 64'(rsp_cyc), 64'(t + 8));
    ar_wait = 0;
    slv_resp = 2'b00;

    b_wait = 20;
    req_cmd(0, 1'b1, 32'h3C, 32'h0BAD_F00D, 4'hF, t);
    for (int k = 0; k < 50 && !BREADY; k++) @(negedge clk);
    chk("rst_in_wresp", {63'd0, BREADY}, 64'd1);
    @(negedge clk);
    #1 rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_valids", {59'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'd0);
    chk("midrst_rsp", {62'd0, RSP_VALID}, 64'd0);
    @(negedge clk);
    chk("midrst_rsp_hold", {62'd0, RSP_VALID}, 64'd0);
    #1 rstn = 1'b1;
    b_wait = 0;
    gnt_log.delete();
    gnt_cyc.delete();
    fork
      req_cmd(1, 1'b0, 32'h08, 32'd0, 4'h0, tb);
      req_cmd(0, 1'b0, 32'h24, 32'd0, 4'h0, ta);
    join
    drain();
    chk("midrst_winner", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
